// File: rtl/mdbrot_pixel_sequencer.sv
// Mandelbrot pixel sequencer: walks a H_PIX x V_PIX frame in raster order.
// Each pixel is issued to an escape-time core, and the returned count is mapped to a plot.
// Latency: at least 3 cycles per pixel (ISSUE, WAIT, PLOT); done rises the cycle after the last plot.
// Backpressure: c_valid holds until c_ready and it_ready holds until it_valid.
// Only one coordinate is ever outstanding.
//
// Ports:
//   clock, resetn            - clock, asynchronous active-low reset
//   start                    - level request to render one frame
//   max_iter, re_min,        - frame setup, captured when the frame starts
//   im_max, step
//   c_re/c_im/c_valid/c_ready   - coordinate handshake to the escape-time core
//   it_count/it_valid/it_ready  - iteration-count handshake from the core
//   vga_x/vga_y/vga_colour/vga_plot - single-cycle pixel write strobe
//   done                     - frame complete; held until start drops
module mdbrot_pixel_sequencer #(
  parameter int H_PIX = 160,
  parameter int V_PIX = 120,
  parameter int DW    = 32
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic [12:0]   max_iter,
  input  logic [DW-1:0] re_min,
  input  logic [DW-1:0] im_max,
  input  logic [DW-1:0] step,
  output logic [DW-1:0] c_re,
  output logic [DW-1:0] c_im,
  output logic          c_valid,
  input  logic          c_ready,
  input  logic [12:0]   it_count,
  input  logic          it_valid,
  output logic          it_ready,
  output logic [7:0]    vga_x,
  output logic [6:0]    vga_y,
  output logic [2:0]    vga_colour,
  output logic          vga_plot,
  output logic          done
);

  localparam logic [7:0] X_LAST = 8'(H_PIX - 1);
  localparam logic [6:0] Y_LAST = 7'(V_PIX - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PLOT, DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic [12:0]   max_iter_q, max_iter_d;
  logic [DW-1:0] re_min_q, re_min_d;
  logic [DW-1:0] step_q, step_d;
  logic [DW-1:0] c_re_q, c_re_d;
  // im_max needs no separate copy: c_im_q is loaded with it at frame start
  // and only ever stepped from there.
  logic [DW-1:0] c_im_q, c_im_d;
  logic          c_valid_q, c_valid_d;
  logic          it_ready_q, it_ready_d;
  logic          vga_plot_q, vga_plot_d;
  logic          done_q, done_d;
  logic [7:0]    vga_x_q, vga_x_d;
  logic [6:0]    vga_y_q, vga_y_d;
  logic [2:0]    colour_q, colour_d;
  logic [2:0]    colour_map;

  // Points that reach the limit are in the set and are drawn black.
  // Otherwise the low count bits pick the colour, with black remapped to
  // white so that escaping points are never drawn black.
  always_comb begin
    colour_map = 3'b000;
    if (it_count < max_iter_q) begin
      colour_map = (it_count[2:0] == 3'b000) ? 3'b111 : it_count[2:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    max_iter_d = max_iter_q;
    re_min_d   = re_min_q;
    step_d     = step_q;
    c_re_d     = c_re_q;
    c_im_d     = c_im_q;
    vga_x_d    = vga_x_q;
    vga_y_d    = vga_y_q;
    colour_d   = colour_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          max_iter_d = max_iter;
          re_min_d   = re_min;
          step_d     = step;
          x_d        = '0;
          y_d        = '0;
          c_re_d     = re_min;
          c_im_d     = im_max;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (c_valid_q && c_ready) state_d = WAIT;
      end
      WAIT: begin
        if (it_ready_q && it_valid) begin
          colour_d = colour_map;
          vga_x_d  = x_q;
          vga_y_d  = y_q;
          state_d  = PLOT;
        end
      end
      PLOT: begin
        if (x_q == X_LAST) begin
          if (y_q == Y_LAST) begin
            state_d = DONE;
          end else begin
            x_d     = '0;
            y_d     = y_q + 7'd1;
            c_re_d  = re_min_q;
            // Rows run top to bottom, so the imaginary part decreases.
            c_im_d  = c_im_q - step_q;
            state_d = ISSUE;
          end
        end else begin
          x_d     = x_q + 8'd1;
          c_re_d  = c_re_q + step_q;
          state_d = ISSUE;
        end
      end
      DONE: begin
        // Require start to drop so a held start renders only one frame.
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state and then registered, so they
    // line up exactly with the state they describe.
    c_valid_d  = (state_d == ISSUE);
    it_ready_d = (state_d == WAIT);
    vga_plot_d = (state_d == PLOT);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      max_iter_q <= '0;
      re_min_q   <= '0;
      step_q     <= '0;
      c_re_q     <= '0;
      c_im_q     <= '0;
      c_valid_q  <= 1'b0;
      it_ready_q <= 1'b0;
      vga_plot_q <= 1'b0;
      done_q     <= 1'b0;
      vga_x_q    <= '0;
      vga_y_q    <= '0;
      colour_q   <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      max_iter_q <= max_iter_d;
      re_min_q   <= re_min_d;
      step_q     <= step_d;
      c_re_q     <= c_re_d;
      c_im_q     <= c_im_d;
      c_valid_q  <= c_valid_d;
      it_ready_q <= it_ready_d;
      vga_plot_q <= vga_plot_d;
      done_q     <= done_d;
      vga_x_q    <= vga_x_d;
      vga_y_q    <= vga_y_d;
      colour_q   <= colour_d;
    end
  end

  assign c_re       = c_re_q;
  assign c_im       = c_im_q;
  assign c_valid    = c_valid_q;
  assign it_ready   = it_ready_q;
  assign vga_plot   = vga_plot_q;
  assign done       = done_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = colour_q;

endmodule

// File: tb/tb_mdbrot_pixel_sequencer.sv
module tb_mdbrot_pixel_sequencer;

  localparam int H = 160;
  localparam int V = 120;

  logic        clock = 1'b0;
  logic        resetn, start, c_ready, it_valid;
  logic [12:0] max_iter, it_count;
  logic [31:0] re_min, im_max, step, c_re, c_im;
  logic        c_valid, it_ready, vga_plot, done;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;

  mdbrot_pixel_sequencer #(.H_PIX(H), .V_PIX(V), .DW(32)) dut (
    .clock(clock), .resetn(resetn), .start(start), .max_iter(max_iter),
    .re_min(re_min), .im_max(im_max), .step(step),
    .c_re(c_re), .c_im(c_im), .c_valid(c_valid), .c_ready(c_ready),
    .it_count(it_count), .it_valid(it_valid), .it_ready(it_ready),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .done(done)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int plot_cnt = 0;

  // Scoreboard of expected plots {x, y, colour}, pushed when a response is driven.
  logic [17:0] exp_q[$];

  // Reference model of the frame walk.
  int          exp_x, exp_y;
  logic [31:0] exp_re, exp_im, lat_re_min, lat_step;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_c_re"}, c_re, 0);
    chk({tag, "_c_im"}, c_im, 0);
    chk({tag, "_c_valid"}, c_valid, 0);
    chk({tag, "_it_ready"}, it_ready, 0);
    chk({tag, "_vga_x"}, vga_x, 0);
    chk({tag, "_vga_y"}, vga_y, 0);
    chk({tag, "_colour"}, vga_colour, 0);
    chk({tag, "_plot"}, vga_plot, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic model_start(input logic [31:0] rmin, input logic [31:0] imax, input logic [31:0] st);
    exp_x = 0; exp_y = 0;
    exp_re = rmin; exp_im = imax;
    lat_re_min = rmin; lat_step = st;
  endtask

  task automatic wait_cvalid(input string tag);
    int n = 0;
    while (c_valid !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_cvalid_timeout"}, c_valid, 1);
  endtask

  // One pixel: wait for the issue, optional coordinate backpressure (with
  // an optional spurious it_valid), handshake, optional response delay,
  // then the response. Returns at the negedge where the plot is visible.
  task automatic do_pixel(input int bp, input int rsp, input logic [12:0] cnt,
                          input logic [2:0] col, input bit spur);
    wait_cvalid("issue");
    chk("c_re", c_re, exp_re);
    chk("c_im", c_im, exp_im);
    chk("it_ready_in_issue", it_ready, 0);
    if (bp > 0) begin
      c_ready = 1'b0;
      if (spur) begin it_valid = 1'b1; it_count = 13'd3; end
      for (int i = 0; i < bp; i++) begin
        @(negedge clock);
        chk("bp_c_valid", c_valid, 1);
        chk("bp_c_re", c_re, exp_re);
        chk("bp_c_im", c_im, exp_im);
        chk("bp_no_plot", vga_plot, 0);
      end
      it_valid = 1'b0;
    end
    c_ready = 1'b1;
    @(negedge clock);
    c_ready = 1'b0;
    exp_q.push_back({8'(exp_x), 7'(exp_y), col});
    chk("wait_it_ready", it_ready, 1);
    chk("wait_c_valid", c_valid, 0);
    for (int i = 0; i < rsp; i++) begin
      chk("rsp_no_plot", vga_plot, 0);
      @(negedge clock);
    end
    it_valid = 1'b1;
    it_count = cnt;
    @(negedge clock);
    it_valid = 1'b0;
    it_count = 13'h1fff;
    chk("plot_strobe", vga_plot, 1);
    if (exp_x == H - 1) begin
      exp_x = 0; exp_y++;
      exp_re = lat_re_min; exp_im = exp_im - lat_step;
    end else begin
      exp_x++;
      exp_re = exp_re + lat_step;
    end
  endtask

  // Plot monitor: every strobe must match the oldest expected plot.
  always @(negedge clock) begin
    if (resetn === 1'b1) begin
      chk("excl_valid_ready", c_valid & it_ready, 0);
      if (vga_plot === 1'b1) begin
        plot_cnt++;
        chk("plot_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          logic [17:0] e;
          e = exp_q.pop_front();
          chk("plot_x", vga_x, e[17:10]);
          chk("plot_y", vga_y, e[9:3]);
          chk("plot_colour", vga_colour, e[2:0]);
        end
      end
    end
  end

  initial begin
    // Reset with every input driven non-zero.
    resetn = 1'b0; start = 1'b1; max_iter = 13'd500;
    re_min = 32'hE0000000; im_max = 32'h13333333; step = 32'h00666666;
    c_ready = 1'b1; it_valid = 1'b1; it_count = 13'd7;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    c_ready = 1'b0; it_valid = 1'b0;

    // Partial frame: colour map, backpressure, mid-frame input changes.
    model_start(32'hE0000000, 32'h13333333, 32'h00666666);
    resetn = 1'b1;
    do_pixel(10, 0, 13'd5, 3'b101, 1'b1);
    start = 1'b0; max_iter = 13'd4; re_min = 32'h12345678;
    im_max = 32'h0; step = 32'h1;
    do_pixel(0, 20, 13'd8, 3'b111, 1'b0);
    chk("px1_0_re", c_re, 32'hE0666666);
    do_pixel(0, 0, 13'd499, 3'b011, 1'b0);
    do_pixel(0, 0, 13'd500, 3'b000, 1'b0);
    do_pixel(0, 0, 13'd501, 3'b000, 1'b0);
    for (int p = 5; p < 50; p++) do_pixel(0, 0, 13'd500, 3'b000, 1'b0);

    // Reset arrives at pixel 50 while a coordinate is pending.
    wait_cvalid("px50");
    #1 resetn = 1'b0;
    #1 check_all_zero("midframe_reset");
    exp_q.delete();
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    chk("idle_no_start", c_valid, 0);

    // Full frame; inputs are scrambled mid-frame to show they are latched.
    max_iter = 13'd500; re_min = 32'hE0000000; im_max = 32'h13333333; step = 32'h00666666;
    model_start(32'hE0000000, 32'h13333333, 32'h00666666);
    plot_cnt = 0;
    start = 1'b1;
    for (int p = 0; p < H * V; p++) begin
      do_pixel(0, 0, 13'd500, 3'b000, 1'b0);
      if (p == 0) begin
        start = 1'b0; re_min = 32'h0BADF00D; im_max = 32'h0; step = 32'h00000100;
      end
      if (p == 1) chk("frame_px1_0_re", c_re, 32'hE0666666);
      if (p == H) begin
        chk("px0_1_re", c_re, 32'hE0000000);
        chk("px0_1_im", c_im, 32'h12CCCCCD);
      end
      if (p == 19000) start = 1'b1;
      if (p == H * V - 1) begin
        chk("last_re", c_re, 32'h1F99995A);
        chk("last_im", c_im, 32'hE39999C9);
        chk("last_x", vga_x, 159);
        chk("last_y", vga_y, 119);
        chk("done_during_last_plot", done, 0);
      end
    end
    @(negedge clock);
    chk("done_after_last", done, 1);
    chk("done_no_plot", vga_plot, 0);
    chk("plot_count", plot_cnt, H * V);
    chk("queue_drained", exp_q.size(), 0);

    // start held high: no new frame.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("held_done", done, 1);
      chk("held_no_issue", c_valid, 0);
    end

    // start low for one cycle then high: a new frame begins at (0,0).
    re_min = 32'hE0000000; im_max = 32'h13333333; step = 32'h00666666;
    start = 1'b0;
    @(negedge clock);
    chk("idle_done_low", done, 0);
    start = 1'b1;
    model_start(32'hE0000000, 32'h13333333, 32'h00666666);
    do_pixel(0, 0, 13'd9, 3'b001, 1'b0);
    repeat (2) @(negedge clock);
    chk("queue_final", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdbrot_pixel_sequencer.md
MDBROT_PIXEL_SEQUENCER -- requirements
Module: mdbrot_pixel_sequencer

Interface
- REQ-001: Parameters SHALL be, one per line: name, default, meaning.
  - H_PIX, 160, pixels per row.
  - V_PIX, 120, rows per frame.
  - DW, 32, coordinate width; signed fixed point with 28 fraction bits.
- REQ-002: Ports SHALL be, one per line: name, direction, width, meaning.
  - clock, in, 1, sole clock; all state changes on the rising edge.
  - resetn, in, 1, asynchronous active-low reset.
  - start, in, 1, level request to render one frame.
  - max_iter, in, 13, iteration limit.
  - re_min, in, DW, real coordinate of column 0.
  - im_max, in, DW, imaginary coordinate of row 0.
  - step, in, DW, per-pixel increment.
  - c_re, out, DW, real coordinate issued to the escape-time core.
  - c_im, out, DW, imaginary coordinate issued to the escape-time core.
  - c_valid, out, 1, coordinate valid.
  - c_ready, in, 1, core accepts the coordinate.
  - it_count, in, 13, iteration count returned by the core.
  - it_valid, in, 1, count valid.
  - it_ready, out, 1, sequencer accepts the count.
  - vga_x, out, 8, pixel column.
  - vga_y, out, 7, pixel row.
  - vga_colour, out, 3, pixel colour.
  - vga_plot, out, 1, write strobe.
  - done, out, 1, frame complete.

Function
- REQ-003: The FSM SHALL have exactly these states: IDLE, ISSUE, WAIT, PLOT, DONE.
- REQ-004: In IDLE with start=1, the block SHALL:
  - latch max_iter, re_min, im_max and step;
  - set x=0, y=0, c_re=re_min, c_im=im_max;
  - enter ISSUE on the next edge.
- REQ-005: In IDLE with start=0, the block SHALL remain in IDLE.
- REQ-006: In ISSUE, c_valid SHALL be 1; on a cycle with c_valid=1 and c_ready=1, the FSM SHALL enter WAIT.
- REQ-007: While c_valid=1 and c_ready=0, c_re and c_im SHALL be held stable.
- REQ-008: In WAIT, it_ready SHALL be 1; on it_valid=1, the FSM SHALL latch the colour and enter PLOT.
- REQ-009: it_valid SHALL be ignored outside WAIT.
- REQ-010: The colour map SHALL be:
  - it_count >= latched max_iter -> 3'b000;
  - otherwise it_count[2:0], with 3'b000 replaced by 3'b111.
- REQ-011: In PLOT, vga_plot SHALL be 1 for exactly one cycle, with vga_x=x, vga_y=y and vga_colour=latched colour.
- REQ-012: From PLOT, when x=H_PIX-1 and y=V_PIX-1, the FSM SHALL enter DONE.
- REQ-013: From PLOT, when x<H_PIX-1, the block SHALL set x=x+1, c_re=c_re+step, and enter ISSUE.
- REQ-014: From PLOT, when x=H_PIX-1 and y<V_PIX-1, the block SHALL set x=0, y=y+1, c_re=latched re_min, c_im=c_im-step, and enter ISSUE.
- REQ-015: Coordinate arithmetic SHALL be DW-bit two's complement with wrap-around; no saturation or overflow flag.
- REQ-016: Pixel order SHALL be raster, row-major, starting at (0,0); each pixel SHALL be issued and plotted exactly once per frame.
- REQ-017: At most one coordinate SHALL be outstanding; c_valid and it_ready SHALL never both be 1.
- REQ-018: Minimum cost per pixel SHALL be 3 cycles (ISSUE, WAIT, PLOT).
- REQ-019: In DONE, done SHALL be 1 and vga_plot SHALL be 0; the FSM SHALL return to IDLE only when start=0.
- REQ-020: start deasserting mid-frame SHALL NOT abort the frame.
- REQ-021: Input changes after the REQ-004 latch SHALL have no effect until the next frame.
- REQ-022: vga_plot, c_valid, it_ready and done SHALL be registered outputs.

Reset
- REQ-023: When resetn=0, the block SHALL asynchronously enter IDLE and clear every output and internal register to 0:
  - outputs: c_re, c_im, c_valid, it_ready, vga_x, vga_y, vga_colour, vga_plot, done;
  - internal: x, y, all latched inputs.
- REQ-024: Reset asserted mid-frame SHALL discard any outstanding transaction.
- REQ-025: After resetn rises, the next frame SHALL start only per REQ-004.

Verification
- REQ-026: Reset: resetn=0 with all inputs driven -> every output is 0 within the same cycle, without a clock edge.
- REQ-027: Full frame with core model c_ready=1, response after 1 cycle, it_count=500, max_iter=500 ->
  - 19200 vga_plot pulses in raster order, all colour 000;
  - done=1 the cycle after the pulse at (159,119).
- REQ-028: re_min=0xE0000000, im_max=0x13333333, step=0x00666666 ->
  - pixel (1,0): c_re=0xE0666666;
  - pixel (0,1): c_re=0xE0000000, c_im=0x12CCCCCD;
  - pixel (159,119): c_re=0x1F99995A, c_im=0xE39999C9.
- REQ-029: Colour map with max_iter=500:
  - it_count=5 -> 101;
  - it_count=8 -> 111;
  - it_count=499 -> 011;
  - it_count=500 or 501 -> 000.
- REQ-030: Backpressure:
  - c_ready=0 for 10 cycles -> c_valid=1 and c_re/c_im unchanged throughout;
  - it_valid delayed 20 cycles -> no vga_plot pulse until 1 cycle after it_valid;
  - spurious it_valid during ISSUE -> ignored.
- REQ-031: Control:
  - resetn pulse at pixel 50 -> all outputs 0, then restart from (0,0) on start;
  - start held high after done -> no new frame;
  - start low for 1 cycle then high -> new frame begins.
